// File: rtl/ysyx_22050518_shifter_pipe.sv
// ysyx_22050518_shifter_pipe
// Pipelined shift unit for the NPC execute stage. It performs SLL/SRL/SRA and
// their RV64 word forms (32-bit result sign-extended from bit 31). The
// log2(XLEN) mux levels are spread over STAGES register stages, and both sides
// use a valid/ready handshake. A flush input kills everything in flight.
// Optional feature: define YSYX_22050518_SHIFTER_ROT_EN to enable ROL/ROR and
// ROLW/RORW. Without it the rotate codes are reported as illegal.
module ysyx_22050518_shifter_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_src,
  input  logic [5:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int LVLS = $clog2(XLEN);
  localparam int PER  = (LVLS + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [3:0]       op_q    [STAGES];
  logic [3:0]       op_d    [STAGES];
  logic [XLEN-1:0]  val_q   [STAGES];
  logic [XLEN-1:0]  val_d   [STAGES];
  logic [5:0]       sh_q    [STAGES];
  logic [5:0]       sh_d    [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];
  logic             ill_q   [STAGES];
  logic             ill_d   [STAGES];

  logic             adv       [STAGES];
  logic             src_valid [STAGES];
  logic [3:0]       src_op    [STAGES];
  logic [XLEN-1:0]  src_val   [STAGES];
  logic [5:0]       src_sh    [STAGES];
  logic [TAG_W-1:0] src_tag   [STAGES];
  logic             src_ill   [STAGES];
  logic [XLEN-1:0]  stage_res [STAGES];

  logic             in_ill;
  logic [63:0]      word64;
  logic [XLEN-1:0]  prep_val;
  logic [5:0]       prep_sh;

  // Apply the mux levels owned by one stage. Word rotates work because the
  // operand is duplicated into both halves, so a 64-bit rotate by less than 32
  // keeps rotating the low word correctly.
  function automatic logic [XLEN-1:0] shift_levels(input logic [XLEN-1:0] v,
                                                   input logic [2:0] code,
                                                   input logic [5:0] sh,
                                                   input int stage);
    logic [XLEN-1:0] r;
    r = v;
    for (int j = 0; j < LVLS; j++) begin
      if ((j / PER) == stage && sh[j]) begin
        case (code)
          3'd0: r = r << (1 << j);
          3'd1: r = r >> (1 << j);
          3'd2: r = $signed(r) >>> (1 << j);
`ifdef YSYX_22050518_SHIFTER_ROT_EN
          3'd3: r = (r << (1 << j)) | (r >> (XLEN - (1 << j)));
          3'd4: r = (r >> (1 << j)) | (r << (XLEN - (1 << j)));
`endif
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  // The last stage zeroes illegal results and sign-extends word forms.
  function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v,
                                               input logic word,
                                               input logic ill);
    logic [63:0] ext;
    ext = {{32{v[31]}}, v[31:0]};
    if (ill) return '0;
    if (word) return ext[XLEN-1:0];
    return v;
  endfunction

  // Decode legality and prepare the operand and amount before the first level.
  always_comb begin
    in_ill = (in_op[2:0] > 3'd4) || (in_op[3] && XLEN != 64);
`ifndef YSYX_22050518_SHIFTER_ROT_EN
    if (in_op[2:0] == 3'd3 || in_op[2:0] == 3'd4) in_ill = 1'b1;
`endif
    case (in_op[2:0])
      3'd2:    word64 = {{32{in_src[31]}}, in_src[31:0]};
`ifdef YSYX_22050518_SHIFTER_ROT_EN
      3'd3,
      3'd4:    word64 = {in_src[31:0], in_src[31:0]};
`endif
      default: word64 = {32'b0, in_src[31:0]};
    endcase
    prep_val = in_op[3] ? word64[XLEN-1:0] : in_src;
    prep_sh  = in_op[3] ? {1'b0, in_shamt[4:0]} : in_shamt;
  end

  // Advance chain from the output back to the input.
  always_comb begin
    for (int k = 0; k < STAGES; k++) adv[k] = 1'b0;
    adv[LAST] = out_ready || !valid_q[LAST];
    for (int k = LAST - 1; k >= 0; k--) adv[k] = !valid_q[k+1] || adv[k+1];
  end

  assign in_ready = adv[0] && !flush;

  // Gather what each stage would capture and the shifted value it produces.
  always_comb begin
    src_valid[0] = in_valid && in_ready;
    src_op[0]    = in_op;
    src_val[0]   = prep_val;
    src_sh[0]    = prep_sh;
    src_tag[0]   = in_tag;
    src_ill[0]   = in_ill;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_op[k]    = op_q[k-1];
      src_val[k]   = val_q[k-1];
      src_sh[k]    = sh_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_ill[k]   = ill_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      stage_res[k] = shift_levels(src_val[k], src_op[k][2:0], src_sh[k], k);
      if (k == LAST) stage_res[k] = finalize(stage_res[k], src_op[k][3], src_ill[k]);
    end
  end

  // Next-state: flush clears valids, advancing stages load their upstream data.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      op_d[k]    = op_q[k];
      val_d[k]   = val_q[k];
      sh_d[k]    = sh_q[k];
      tag_d[k]   = tag_q[k];
      ill_d[k]   = ill_q[k];
      if (flush) valid_d[k] = 1'b0;
      else if (adv[k]) valid_d[k] = src_valid[k];
      if (adv[k] && src_valid[k]) begin
        op_d[k]  = src_op[k];
        val_d[k] = stage_res[k];
        sh_d[k]  = src_sh[k];
        tag_d[k] = src_tag[k];
        ill_d[k] = src_ill[k];
      end
    end
  end

  // Pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        op_q[k]    <= '0;
        val_q[k]   <= '0;
        sh_q[k]    <= '0;
        tag_q[k]   <= '0;
        ill_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        op_q[k]    <= op_d[k];
        val_q[k]   <= val_d[k];
        sh_q[k]    <= sh_d[k];
        tag_q[k]   <= tag_d[k];
        ill_q[k]   <= ill_d[k];
      end
    end
  end

  assign out_valid   = valid_q[LAST];
  assign out_result  = val_q[LAST];
  assign out_tag     = tag_q[LAST];
  assign out_illegal = ill_q[LAST];

endmodule

// File: tb/tb_ysyx_22050518_shifter_pipe.sv
// Self-checking bench for ysyx_22050518_shifter_pipe (XLEN=64, STAGES=2).
// Expected results are queued at acceptance and compared when the DUT hands
// a result to the consumer.
module tb_ysyx_22050518_shifter_pipe;
  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = '0;
  logic [XLEN-1:0]  in_src = '0;
  logic [5:0]       in_shamt = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  ysyx_22050518_shifter_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src(in_src), .in_shamt(in_shamt), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Reference model written directly from the instruction semantics.
  function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] src,
                                 input logic [5:0] sh, input logic [TAG_W-1:0] tag);
    logic [31:0] lo, r32;
    logic [63:0] r;
    logic [4:0]  s5;
    logic [5:0]  s6;
    logic        ill;
    ill = (op[2:0] > 3'd4);
`ifndef YSYX_22050518_SHIFTER_ROT_EN
    if (op[2:0] == 3'd3 || op[2:0] == 3'd4) ill = 1'b1;
`endif
    lo = src[31:0];
    s5 = sh[4:0];
    s6 = sh;
    r = '0;
    if (op[3]) begin
      case (op[2:0])
        3'd0: r32 = lo << s5;
        3'd1: r32 = lo >> s5;
        3'd2: r32 = $signed(lo) >>> s5;
        3'd3: r32 = (lo << s5) | (lo >> (32 - int'(s5)));
        3'd4: r32 = (lo >> s5) | (lo << (32 - int'(s5)));
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op[2:0])
        3'd0: r = src << s6;
        3'd1: r = src >> s6;
        3'd2: r = $signed(src) >>> s6;
        3'd3: r = (src << s6) | (src >> (64 - int'(s6)));
        3'd4: r = (src >> s6) | (src << (64 - int'(s6)));
        default: r = '0;
      endcase
    end
    if (ill) r = '0;
    return {r, tag, ill};
  endfunction

  // Scoreboard: every result the consumer takes must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_result: got tag=%0d result=%h, required no result", out_tag, out_result);
      end else begin
        mon_e = q.pop_front();
        if ({out_result, out_tag, out_illegal} !== {mon_e.res, mon_e.tag, mon_e.ill}) begin
          bad++;
          $display("[TB] FAIL result: got res=%h tag=%0d ill=%0b, required res=%h tag=%0d ill=%0b",
                   out_result, out_tag, out_illegal, mon_e.res, mon_e.tag, mon_e.ill);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic [XLEN-1:0] src, input logic [5:0] sh,
                          input logic [TAG_W-1:0] tag, input exp_t e, output logic acc);
    in_op = op; in_src = src; in_shamt = sh; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    if (acc) q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [3:0] op, input logic [XLEN-1:0] src, input logic [5:0] sh,
                            input logic [TAG_W-1:0] tag, output logic acc);
    send_exp(op, src, sh, tag, model(op, src, sh, tag), acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("[TB] FAIL reset_result: got %h required 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("[TB] FAIL reset_tag: got %0d required 0", out_tag); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal: got %b required 0", out_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_full_shifts();
    logic acc;
    out_ready = 1'b1;
    send_exp(4'b0010, 64'h8000_0000_0000_0000, 6'd63, 5'd1, {64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0}, acc);
    send_exp(4'b0001, 64'h8000_0000_0000_0000, 6'd63, 5'd2, {64'h1, 5'd2, 1'b0}, acc);
    send_exp(4'b0000, 64'h1, 6'd63, 5'd3, {64'h8000_0000_0000_0000, 5'd3, 1'b0}, acc);
    for (int i = 0; i < 8; i++)
      send_model({1'b0, 3'($urandom_range(0, 2))}, {$urandom, $urandom}, 6'($urandom), 5'(i + 4), acc);
    drain();
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL full_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_latency();
    int cyc;
    logic [3:0] ops [3];
    logic [5:0] shs [3];
    ops[0] = 4'b0001; shs[0] = 6'd0;
    ops[1] = 4'b0000; shs[1] = 6'd63;
    ops[2] = 4'b1010; shs[2] = 6'd31;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = ops[i]; in_src = {$urandom, $urandom}; in_shamt = shs[i]; in_tag = 5'(20 + i);
      in_valid = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL latency_accept%0d: got %b required 1", i, in_ready); end
      if (in_ready) q.push_back(model(in_op, in_src, in_shamt, in_tag));
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 10) begin tick(); cyc++; end
      total++; if (cyc != STAGES - 1) begin bad++; $display("[TB] FAIL latency%0d: got %0d extra edges required %0d", i, cyc, STAGES - 1); end
      drain();
    end
  endtask

  task automatic test_word_forms();
    logic acc;
    out_ready = 1'b1;
    send_exp(4'b1000, 64'h0000_0000_4000_0000, 6'd1, 5'd1, {64'hFFFF_FFFF_8000_0000, 5'd1, 1'b0}, acc);
    send_exp(4'b1010, 64'hFFFF_FFFF_8000_0000, 6'd31, 5'd2, {64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1'b0}, acc);
    send_exp(4'b1001, 64'h1234_5678_9ABC_DEF0, 6'h20, 5'd3, {64'hFFFF_FFFF_9ABC_DEF0, 5'd3, 1'b0}, acc);
    send_exp(4'b1001, 64'h0000_0000_8000_0000, 6'd0, 5'd4, {64'hFFFF_FFFF_8000_0000, 5'd4, 1'b0}, acc);
    for (int i = 0; i < 8; i++)
      send_model({1'b1, 3'($urandom_range(0, 2))}, {$urandom, $urandom}, 6'($urandom), 5'(i + 5), acc);
    drain();
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL word_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_model(4'($urandom), {$urandom, $urandom}, 6'($urandom), 5'(i), acc);
      total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept%0d: got %b required 1", i, acc); end
    end
    drain();
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL b2b_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_backpressure();
    int accepted;
    logic [TAG_W-1:0] tag;
    logic have_snap;
    logic [XLEN+TAG_W:0] snap;
    out_ready = 1'b0;
    tag = 5'd1;
    accepted = 0;
    have_snap = 1'b0;
    snap = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_op = {1'b0, 3'($urandom_range(0, 2))}; in_src = {$urandom, $urandom};
      in_shamt = 6'($urandom); in_tag = tag;
      @(negedge clk);
      if (out_valid) begin
        if (have_snap) begin
          total++;
          if ({out_result, out_tag, out_illegal} !== snap) begin
            bad++; $display("[TB] FAIL stall_hold: got %h required %h", {out_result, out_tag, out_illegal}, snap);
          end
        end else begin
          snap = {out_result, out_tag, out_illegal};
          have_snap = 1'b1;
        end
      end
      if (in_ready) begin
        q.push_back(model(in_op, in_src, in_shamt, in_tag));
        accepted++;
        tag++;
      end
      tick();
    end
    @(negedge clk);
    total++; if (accepted != STAGES) begin bad++; $display("[TB] FAIL bp_accepted: got %0d required %0d", accepted, STAGES); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got %b required 0", in_ready); end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_op = {1'b0, 3'($urandom_range(0, 2))}; in_src = {$urandom, $urandom};
      in_shamt = 6'($urandom); in_tag = tag;
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_stream_valid%0d: got %b required 1", i, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_stream_ready%0d: got %b required 1", i, in_ready); end
      if (in_ready) begin
        q.push_back(model(in_op, in_src, in_shamt, in_tag));
        tag++;
      end
      tick();
    end
    in_valid = 1'b0;
    drain();
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL bp_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      in_op = 4'b0000; in_src = {$urandom, $urandom}; in_shamt = 6'($urandom); in_tag = 5'(10 + i);
      @(negedge clk);
      if (in_ready) q.push_back(model(in_op, in_src, in_shamt, in_tag));
      tick();
    end
    flush = 1'b1;
    out_ready = 1'b1;
    in_op = 4'b0001; in_src = 64'hDEAD_BEEF_0000_0001; in_shamt = 6'd3; in_tag = 5'd20;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready: got %b required 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid: got %b required 0", out_valid); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_late: got %b required 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic acc;
    out_ready = 1'b1;
    send_exp(4'b0101, {$urandom, $urandom}, 6'($urandom), 5'd7, {64'h0, 5'd7, 1'b1}, acc);
    send_exp(4'b0111, {$urandom, $urandom}, 6'($urandom), 5'd8, {64'h0, 5'd8, 1'b1}, acc);
    send_exp(4'b1110, {$urandom, $urandom}, 6'($urandom), 5'd9, {64'h0, 5'd9, 1'b1}, acc);
`ifdef YSYX_22050518_SHIFTER_ROT_EN
    send_exp(4'b0100, 64'h1, 6'd1, 5'd10, {64'h8000_0000_0000_0000, 5'd10, 1'b0}, acc);
`else
    send_exp(4'b0100, 64'h1, 6'd1, 5'd10, {64'h0, 5'd10, 1'b1}, acc);
`endif
    send_model(4'b1011, {$urandom, $urandom}, 6'($urandom), 5'd11, acc);
    send_model(4'b0011, {$urandom, $urandom}, 6'($urandom), 5'd12, acc);
    drain();
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL illegal_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      in_op = 4'b0000; in_src = 64'hFF; in_shamt = 6'd4; in_tag = 5'(9 + i);
      @(negedge clk);
      if (in_ready) q.push_back(model(in_op, in_src, in_shamt, in_tag));
      tick();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_valid: got %b required 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid: got %b required 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("[TB] FAIL mid_reset_result: got %h required 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("[TB] FAIL mid_reset_tag: got %0d required 0", out_tag); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_illegal: got %b required 0", out_illegal); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_stale: got %b required 0", out_valid); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Run the scenarios in sequence and print the summary.
  initial begin
    test_reset();
    test_full_shifts();
    test_latency();
    test_word_forms();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050518_shifter_pipe.md
# ysyx_22050518_shifter_pipe

Pipelined, parametrised shift unit for the NPC execute stage; supersedes the single-cycle combinational shifter. Performs logical/arithmetic shifts, including RV64 word (`*W`) forms with correct 32-bit sign extension, over a configurable number of register stages. Uses a valid/ready handshake on both sides and supports a pipeline flush. Carries a sideband tag so the issue logic can match results to instructions.

## Interface
Parameters:
- `XLEN`, 64: datapath width. Legal values are 32 or 64.
- `STAGES`, 2: number of register stages, 1..3. Equals latency in cycles.
- `TAG_W`, 5: sideband tag width (rd index).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: unit can accept a request this cycle.
- `in_op`, in, 4: bit3 = word form; bits[2:0]: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR.
- `in_src`, in, XLEN: operand.
- `in_shamt`, in, 6: shift amount. Only the low log2(XLEN) bits are used; word forms use bits[4:0].
- `in_tag`, in, TAG_W: sideband, passed through unchanged.
- `flush`, in, 1: kill all in-flight requests.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_result`, out, XLEN: shift result.
- `out_tag`, out, TAG_W: tag of the result.
- `out_illegal`, out, 1: the op code was not supported; `out_result` is 0.

## Operation
- **Full-width ops:**
  - SLL: `src << sh`.
  - SRL: zero-fill right shift.
  - SRA: right shift filling with `src[XLEN-1]`.
  - `sh = shamt[log2(XLEN)-1:0]`.
- **Word ops** (bit3 = 1, XLEN = 64 only):
  - Operand is `src[31:0]`; `sh = shamt[4:0]`.
  - The 32-bit result is sign-extended from its bit 31 to 64 bits. This applies to SLLW and SRLW as well.
  - Example: SRLW of `0x0000_0000_8000_0000` by 0 gives `0xFFFF_FFFF_8000_0000`.
- **Rotate ops** (ROL, ROR, and their W forms) exist only under the configuration macro.
- **Illegal codes** produce `out_illegal=1` and `out_result=0`, and still consume a pipeline slot. The following are illegal:
  - bits[2:0] in 101–111;
  - any word form when XLEN = 32;
  - rotates when the macro is not defined.
- **Pipeline structure:**
  - The log2(XLEN) mux levels (amount bits, LSB first) are split across the STAGES registers. Earlier stages take ceil(levels/STAGES) levels.
  - Each stage has a valid bit plus op, partial result, remaining shamt, tag and illegal flag.
- **Advance rule:**
  - Last stage advances when `out_ready`, or when it is empty.
  - Stage k advances when stage k+1 is empty or advancing.
  - `in_ready` = first stage empty or advancing, AND `!flush`.
- A request is accepted on `in_valid && in_ready`. The unit sustains throughput of one request per cycle.
- **Stall:** while `out_valid && !out_ready`, `out_result`, `out_tag` and `out_illegal` hold stable.
- **Flush:**
  - All valid bits are cleared at the next edge.
  - No request is accepted in a flush cycle, because `in_ready=0`.
  - A result presented in the flush cycle may still be taken by the consumer if `out_ready=1`. The consumer must discard it by its own flush logic.
- **Reset:** all valid bits are 0, `out_result=0`, `out_tag=0`, `out_illegal=0`. `in_ready` is 1 once reset is released.

## Timing
- Latency is STAGES cycles. A request accepted at edge N shows `out_valid=1` after edge N+STAGES-1, with no backpressure.
- With STAGES=1, the result is registered one edge after acceptance.
- Shifts by 0 and by the maximum amount (63, or 31 for word forms) have the same latency as all other amounts. There is no early-out.
- Simultaneous output and input handshake on a full pipe: the last stage drains, all stages shift, and the new request enters with no bubble.
- `rst_n` asserted mid-operation clears all state immediately (asynchronously). In-flight requests are lost.

## Configuration
- **`YSYX_22050518_SHIFTER_ROT_EN`**
  - Defined: op 011 is ROL and 100 is ROR. ROLW/RORW rotate `src[31:0]` by `shamt[4:0]` and sign-extend the result from bit 31.
  - Undefined: the rotate codes are illegal and the rotate mux logic is not synthesised.

## Test plan
- **Full-width shifts:** XLEN=64, STAGES=2. SRA `0x8000_0000_0000_0000` by 63 -> `0xFFFF_FFFF_FFFF_FFFF`; SRL same operand -> `0x1`; SLL `0x1` by 63 -> `0x8000_0000_0000_0000`. Each result appears 2 cycles after acceptance.
- **Word forms:** SLLW `0x0000_0000_4000_0000` by 1 -> `0xFFFF_FFFF_8000_0000`. SRAW `0xFFFF_FFFF_8000_0000` by 31 -> all ones. SRLW by 32 (`shamt=0x20`) uses amount 0 -> sign-extended low word.
- **Backpressure:** hold `out_ready=0` with `in_valid=1` for 6 cycles. `in_ready` drops after STAGES accepted requests. Then raise `out_ready`: results emerge in order, tags 1, 2, 3…, with no loss or duplication, then one result per cycle.
- **Flush:** assert `flush` with a full pipe. `in_ready=0` that cycle, and `out_valid=0` the next cycle. A request offered in the flush cycle is not accepted.
- **Illegal codes and rotates:** op 101 -> `out_illegal=1`, result 0. With the macro defined, ROR `0x1` by 1 -> `0x8000_0000_0000_0000`. With the macro undefined, the same request -> illegal.
- **Reset mid-stream:** pulse `rst_n` low between edges with requests in flight. Outputs are immediately 0 and valid is 0. No stale result appears after reset is released.
